// File: rtl/actuador_puertas_if.sv
// Command/status bundle between the door controller and the door actuator stage.
interface actuador_puertas_if;
  logic [1:0] salida_puertas;
  logic       sensor;
  logic [1:0] puertas;
  logic       timeout;
  logic       motor_abrir;
  logic       motor_cerrar;
  logic [7:0] reaperturas;

  // Controller side: issues commands and forwards the obstacle sensor.
  modport master (
    output salida_puertas,
    output sensor,
    input  puertas,
    input  timeout,
    input  motor_abrir,
    input  motor_cerrar,
    input  reaperturas
  );

  // Actuator side: consumes commands and reports door status.
  modport slave (
    input  salida_puertas,
    input  sensor,
    output puertas,
    output timeout,
    output motor_abrir,
    output motor_cerrar,
    output reaperturas
  );
endinterface

// File: rtl/actuador_puertas.sv
// Door actuator: runs the travel and open-hold timers and drives the motors.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   CERRADA  | door fully closed, waiting for an open command
//   ABRIENDO | motor opening, posicion counting up towards T_RECORRIDO
//   ABIERTA  | door fully open, espera counting the hold time
//   CERRANDO | motor closing, posicion counting down; obstacle reverses
//
// The state encoding equals the puertas code, so puertas is the state register.
module actuador_puertas #(
  parameter int T_RECORRIDO = 16,
  parameter int T_ESPERA    = 50,
  parameter int ANCHO       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  actuador_puertas_if.slave   bus
);

  typedef enum logic [1:0] {
    CERRADA  = 2'b00,
    ABIERTA  = 2'b01,
    ABRIENDO = 2'b10,
    CERRANDO = 2'b11
  } estado_t;

  localparam logic [ANCHO-1:0] RECORRIDO = ANCHO'(T_RECORRIDO);
  localparam logic [ANCHO-1:0] ESPERA    = ANCHO'(T_ESPERA);
  localparam logic [ANCHO-1:0] UNO       = ANCHO'(1);

  estado_t          estado, estado_n;
  logic [ANCHO-1:0] posicion, posicion_n;
  logic [ANCHO-1:0] espera, espera_n;
  logic [7:0]       reaperturas, reaperturas_n;

  logic cmd_abrir, cmd_cerrar;

  // Command 11 decodes to neither open nor close.
  assign cmd_abrir  = (bus.salida_puertas == 2'b01);
  assign cmd_cerrar = (bus.salida_puertas == 2'b10);

  // State, timers and reversal counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado      <= CERRADA;
      posicion    <= '0;
      espera      <= '0;
      reaperturas <= '0;
    end else begin
      estado      <= estado_n;
      posicion    <= posicion_n;
      espera      <= espera_n;
      reaperturas <= reaperturas_n;
    end
  end

  // Next-state and timer update.
  always_comb begin
    estado_n      = estado;
    posicion_n    = posicion;
    espera_n      = espera;
    reaperturas_n = reaperturas;
    case (estado)
      CERRADA: begin
        if (cmd_abrir) estado_n = ABRIENDO;
      end
      ABRIENDO: begin
        // >= also covers a reversal taken at full travel (posicion == T_RECORRIDO).
        if (posicion >= RECORRIDO - UNO) begin
          estado_n   = ABIERTA;
          posicion_n = RECORRIDO;
          espera_n   = '0;
        end else begin
          posicion_n = posicion + UNO;
        end
      end
      ABIERTA: begin
        if (bus.sensor) begin
          espera_n = '0;
        end else if (cmd_cerrar) begin
          estado_n = CERRANDO;
        end else if (cmd_abrir) begin
          espera_n = '0;
        end else if (espera < ESPERA) begin
          espera_n = espera + UNO;
        end
      end
      CERRANDO: begin
        if (bus.sensor) begin
          estado_n = ABRIENDO;
          if (reaperturas != 8'hFF) reaperturas_n = reaperturas + 8'd1;
        end else if (cmd_abrir) begin
          estado_n = ABRIENDO;
        end else if (posicion <= UNO) begin
          estado_n   = CERRADA;
          posicion_n = '0;
        end else begin
          posicion_n = posicion - UNO;
        end
      end
      default: estado_n = CERRADA;
    endcase
  end

  assign bus.puertas      = estado;
  assign bus.timeout      = (estado == ABIERTA) && (espera == ESPERA);
  assign bus.motor_abrir  = (estado == ABRIENDO);
  assign bus.motor_cerrar = (estado == CERRANDO);
  assign bus.reaperturas  = reaperturas;

  a_posicion_rango: assert property (@(posedge clk) disable iff (!rst_n)
    posicion <= RECORRIDO)
    else $error("posicion out of range: %0d", posicion);

  a_motores_exclusivos: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.motor_abrir && bus.motor_cerrar))
    else $error("both motors driven");

endmodule

// File: tb/tb_actuador_puertas.sv
// Testbench for actuador_puertas: directed scenarios plus random traffic,
// all compared against a door-behaviour reference model.
module tb_actuador_puertas;
  localparam int TR = 4;
  localparam int TE = 6;

  localparam int M_CLOSED  = 0;
  localparam int M_OPEN    = 1;
  localparam int M_OPENING = 2;
  localparam int M_CLOSING = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  actuador_puertas_if bus ();

  actuador_puertas #(
    .T_RECORRIDO (TR),
    .T_ESPERA    (TE),
    .ANCHO       (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: door mode (as its reported code), travel, hold time, reversals.
  int m_mode, m_pos, m_hold, m_reap;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_CLOSED;
    m_pos  = 0;
    m_hold = 0;
    m_reap = 0;
  endtask

  task automatic model_step(input int c, input int s);
    int cmd;
    cmd = (c == 3) ? 0 : c;
    case (m_mode)
      M_CLOSED: if (cmd == 1) m_mode = M_OPENING;
      M_OPENING: begin
        m_pos = m_pos + 1;
        if (m_pos >= TR) begin
          m_pos  = TR;
          m_mode = M_OPEN;
          m_hold = 0;
        end
      end
      M_OPEN: begin
        if (s != 0)        m_hold = 0;
        else if (cmd == 2) m_mode = M_CLOSING;
        else if (cmd == 1) m_hold = 0;
        else               m_hold = (m_hold + 1 > TE) ? TE : m_hold + 1;
      end
      default: begin
        if (s != 0) begin
          m_mode = M_OPENING;
          m_reap = (m_reap + 1 > 255) ? 255 : m_reap + 1;
        end else if (cmd == 1) begin
          m_mode = M_OPENING;
        end else begin
          m_pos = m_pos - 1;
          if (m_pos == 0) m_mode = M_CLOSED;
        end
      end
    endcase
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".puertas"},  int'(bus.puertas),      m_mode);
    check({tag, ".timeout"},  int'(bus.timeout),      (m_mode == M_OPEN && m_hold == TE) ? 1 : 0);
    check({tag, ".m_abrir"},  int'(bus.motor_abrir),  (m_mode == M_OPENING) ? 1 : 0);
    check({tag, ".m_cerrar"}, int'(bus.motor_cerrar), (m_mode == M_CLOSING) ? 1 : 0);
    check({tag, ".reap"},     int'(bus.reaperturas),  m_reap);
  endtask

  // Apply inputs, clock once, advance model, compare 1 ns after the edge.
  task automatic step(input int c, input int s, input string tag);
    bus.salida_puertas = 2'(c);
    bus.sensor         = (s != 0);
    @(posedge clk);
    model_step(c, s);
    #1;
    compare_all(tag);
  endtask

  task automatic open_full(input string tag);
    step(1, 0, tag);
    for (int i = 0; i < 20 && bus.puertas != 2'b01; i++) step(0, 0, tag);
  endtask

  task automatic close_full(input string tag);
    step(2, 0, tag);
    for (int i = 0; i < 20 && bus.puertas != 2'b00; i++) step(0, 0, tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nm;
    int seen;
    bus.salida_puertas = 2'b00;
    bus.sensor         = 1'b0;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    rst_n = 1'b1;

    // 1: single-cycle open command gives exactly TR cycles of opening.
    step(1, 0, "t1");
    n  = (bus.puertas == 2'b10) ? 1 : 0;
    nm = int'(bus.motor_abrir);
    for (int i = 0; i < 20 && bus.puertas != 2'b01; i++) begin
      step(0, 0, "t1");
      if (bus.puertas == 2'b10) n++;
      nm += int'(bus.motor_abrir);
    end
    check("t1_opening_cycles", n, TR);
    check("t1_motor_cycles", nm, TR);
    check("t1_final_open", int'(bus.puertas), 1);

    // 2: timeout after TE cycles of hold, then close takes TR cycles.
    n = 0;
    for (int i = 0; i < 20 && bus.timeout == 1'b0; i++) begin
      step(0, 0, "t2");
      n++;
    end
    check("t2_timeout_delay", n, TE);
    repeat (3) step(0, 0, "t2");
    check("t2_timeout_held", int'(bus.timeout), 1);
    step(2, 0, "t2");
    check("t2_timeout_drop", int'(bus.timeout), 0);
    n = (bus.puertas == 2'b11) ? 1 : 0;
    for (int i = 0; i < 20 && bus.puertas != 2'b00; i++) begin
      step(0, 0, "t2");
      if (bus.puertas == 2'b11) n++;
    end
    check("t2_closing_cycles", n, TR);
    check("t2_final_closed", int'(bus.puertas), 0);

    // 3: obstacle while closing at posicion 2 reverses and reopens in 2 cycles.
    open_full("t3");
    step(2, 0, "t3");
    step(0, 0, "t3");
    step(0, 0, "t3");
    step(0, 1, "t3");
    check("t3_reverse_state", int'(bus.puertas), 2);
    check("t3_reap_one", int'(bus.reaperturas), 1);
    step(0, 0, "t3");
    check("t3_mid_reopen", int'(bus.puertas), 2);
    step(0, 0, "t3");
    check("t3_reopened", int'(bus.puertas), 1);

    // 4: periodic sensor keeps the door held open; close blocked by obstacle.
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      step(0, (i % 3 == 2) ? 1 : 0, "t4");
      if (bus.timeout) seen = 1;
    end
    check("t4_no_timeout", seen, 0);
    step(2, 1, "t4");
    check("t4_close_blocked", int'(bus.puertas), 1);

    // 5: 300 forced reversals saturate the counter; cmd 11 is a no-op.
    for (int k = 0; k < 300; k++) begin
      step(2, 0, "t5");
      step(0, 1, "t5");
      for (int i = 0; i < 20 && bus.puertas != 2'b01; i++) step(0, 0, "t5");
    end
    check("t5_reap_sat", int'(bus.reaperturas), 255);
    step(3, 0, "t5");
    step(3, 0, "t5");
    check("t5_nop_open", int'(bus.puertas), 1);
    close_full("t5");
    step(3, 1, "t5");
    check("t5_nop_closed", int'(bus.puertas), 0);
    open_full("t5");
    step(2, 0, "t5");
    step(3, 0, "t5");
    check("t5_nop_closing", int'(bus.puertas), 3);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++)
      step(int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0) ? 1 : 0, "rnd");

    // 6: async reset mid-opening, then a clean full open.
    close_full("t6");
    step(1, 0, "t6");
    step(0, 0, "t6");
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all("t6_async");
    check("t6_motor_off", int'(bus.motor_abrir), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, "t6");
    n = (bus.puertas == 2'b10) ? 1 : 0;
    for (int i = 0; i < 20 && bus.puertas != 2'b01; i++) begin
      step(0, 0, "t6");
      if (bus.puertas == 2'b10) n++;
    end
    check("t6_full_open", n, TR);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
